// File: rtl/window_fetch_pkg.sv
// rtl/window_fetch_pkg.sv - shared types, defaults and width helpers for the window fetch unit
//
// Contents:
//   fsm_state_t  - top-level FSM encoding (IDLE, FETCH, DRAIN)
//   DEF_*        - default parameter values used by every file of the block
//   calc_aw()    - address width for an IMAGE_WIDTH x IMAGE_HEIGHT image
//   calc_kw()    - width of a kernel_dim / row / column counter
package window_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fsm_state_t;

    localparam int DEF_DATA_WIDTH   = 16;
    localparam int DEF_IMAGE_WIDTH  = 8;
    localparam int DEF_IMAGE_HEIGHT = 8;
    localparam int DEF_NUM_UNITS    = 2;
    localparam int DEF_MAX_KERNEL   = 4;

    function automatic int calc_aw(input int image_width, input int image_height);
        return $clog2(image_width * image_height);
    endfunction

    function automatic int calc_kw(input int max_kernel);
        return $clog2(max_kernel + 1);
    endfunction

endpackage

// File: rtl/window_fetch_unit_if.sv
// rtl/window_fetch_unit_if.sv - host-side bus of the window fetch unit
//
// Signals:
//   wr_en/wr_addr/wr_data      image memory write port
//   start/kernel_dim/base_addr window request (base_addr per unit)
//   out/out_valid/out_ready    window element stream with back-pressure
//   out_first/out_last         framing of element (0,0) and (k-1,k-1)
//   busy/done/err              status
// Modports:
//   master - host / consumer side
//   slave  - window_fetch_unit side
interface window_fetch_unit_if import window_fetch_pkg::*; #(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
    parameter int NUM_UNITS    = DEF_NUM_UNITS,
    parameter int MAX_KERNEL   = DEF_MAX_KERNEL
);
    localparam int AW = calc_aw(IMAGE_WIDTH, IMAGE_HEIGHT);
    localparam int KW = calc_kw(MAX_KERNEL);

    logic                                  wr_en;
    logic [AW-1:0]                         wr_addr;
    logic [DATA_WIDTH-1:0]                 wr_data;
    logic                                  start;
    logic [KW-1:0]                         kernel_dim;
    logic [NUM_UNITS-1:0][AW-1:0]          base_addr;
    logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]  out;
    logic                                  out_valid;
    logic                                  out_ready;
    logic                                  out_first;
    logic                                  out_last;
    logic                                  busy;
    logic                                  done;
    logic                                  err;

    modport master (
        output wr_en, wr_addr, wr_data, start, kernel_dim, base_addr, out_ready,
        input  out, out_valid, out_first, out_last, busy, done, err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, kernel_dim, base_addr, out_ready,
        output out, out_valid, out_first, out_last, busy, done, err
    );

endinterface

// File: rtl/window_addr_gen.sv
// rtl/window_addr_gen.sv - row/column walker and per-unit address/pad generation
//
// Optional feature: WINDOW_ZERO_PAD_EN (flags elements that fall off the image edge)
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   load         latch kernel_dim/base_addr and clear the counters
//   kernel_dim   window side
//   base_addr    per-unit window top-left address
//   enable       walker is in the fetch phase
//   stall        downstream cannot take a new element this cycle
//   addr         per-unit address of the current element (r,c)
//   pad          per-unit "output zero" flag for the current element
//   first_issue  current element is (0,0)
//   last_issue   current element is (k-1,k-1)
module window_addr_gen import window_fetch_pkg::*; #(
    parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
    parameter int NUM_UNITS    = DEF_NUM_UNITS,
    parameter int MAX_KERNEL   = DEF_MAX_KERNEL,
    localparam int AW = calc_aw(IMAGE_WIDTH, IMAGE_HEIGHT),
    localparam int KW = calc_kw(MAX_KERNEL)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic [KW-1:0]                 kernel_dim,
    input  logic [NUM_UNITS-1:0][AW-1:0]  base_addr,
    input  logic                          enable,
    input  logic                          stall,
    output logic [NUM_UNITS-1:0][AW-1:0]  addr,
    output logic [NUM_UNITS-1:0]          pad,
    output logic                          first_issue,
    output logic                          last_issue
);
    localparam int            IW_BITS = $clog2(IMAGE_WIDTH);
    localparam logic [KW-1:0] ONE     = KW'(1);

    logic [KW-1:0]                k_q;
    logic [KW-1:0]                row_q;
    logic [KW-1:0]                col_q;
    logic [NUM_UNITS-1:0][AW-1:0] base_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            k_q    <= '0;
            row_q  <= '0;
            col_q  <= '0;
            base_q <= '0;
        end else if (load) begin
            k_q    <= kernel_dim;
            base_q <= base_addr;
            row_q  <= '0;
            col_q  <= '0;
        end else if (enable && !stall) begin
            if (col_q == k_q - ONE) begin
                col_q <= '0;
                row_q <= row_q + ONE;
            end else begin
                col_q <= col_q + ONE;
            end
        end
    end

    assign first_issue = (row_q == '0) && (col_q == '0);
    assign last_issue  = (row_q == k_q - ONE) && (col_q == k_q - ONE);

    // Truncation to AW bits gives the modulo-image-size wrap for free.
    always_comb begin
        for (int u = 0; u < NUM_UNITS; u++) begin
            addr[u] = base_q[u] + (AW'(row_q) << IW_BITS) + AW'(col_q);
        end
    end

`ifdef WINDOW_ZERO_PAD_EN
    // Column/row are rebuilt in a width wide enough that base + offset never
    // wraps, so running off the right or bottom edge is detectable.
    localparam int EW = AW + KW + 1;

    logic [NUM_UNITS-1:0][EW-1:0] col_ext;
    logic [NUM_UNITS-1:0][EW-1:0] row_ext;

    always_comb begin
        for (int u = 0; u < NUM_UNITS; u++) begin
            col_ext[u] = EW'(base_q[u][IW_BITS-1:0]) + EW'(col_q);
            row_ext[u] = EW'(base_q[u] >> IW_BITS) + EW'(row_q);
            pad[u]     = (col_ext[u] >= EW'(IMAGE_WIDTH)) || (row_ext[u] >= EW'(IMAGE_HEIGHT));
        end
    end
`else
    assign pad = '0;
`endif

endmodule

// File: rtl/window_fetch_unit.sv
// rtl/window_fetch_unit.sv - convolution window fetcher: image memory, FSM, output register
//
// Optional feature: WINDOW_ZERO_PAD_EN (elements past the image edge read as zero, no wrap)
//
// Ports:
//   clk    clock
//   reset  synchronous active-high reset (memory contents are kept)
//   bus    window_fetch_unit_if.slave: write port, start command, output stream, status
//
// Pipeline: counters -> registered memory read (rd_*) -> output register (out_*).
// Both stages advance together whenever the output register is empty or being
// consumed, so back-pressure freezes the whole pipe without losing a beat.
module window_fetch_unit import window_fetch_pkg::*; #(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
    parameter int NUM_UNITS    = DEF_NUM_UNITS,
    parameter int MAX_KERNEL   = DEF_MAX_KERNEL
) (
    input  logic               clk,
    input  logic               reset,
    window_fetch_unit_if.slave bus
);
    localparam int            AW    = calc_aw(IMAGE_WIDTH, IMAGE_HEIGHT);
    localparam int            KW    = calc_kw(MAX_KERNEL);
    localparam int            DEPTH = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam logic [KW-1:0] K_MAX = KW'(MAX_KERNEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    fsm_state_t                           state;
    logic                                 busy_q;
    logic                                 done_q;
    logic                                 err_q;

    logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] rd_data;
    logic                                 rd_valid;
    logic                                 rd_first;
    logic                                 rd_last;

    logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] out_q;
    logic                                 out_valid_q;
    logic                                 out_first_q;
    logic                                 out_last_q;

    logic [NUM_UNITS-1:0][AW-1:0]         rd_addr;
    logic [NUM_UNITS-1:0]                 rd_pad;
    logic                                 first_issue;
    logic                                 last_issue;

    logic legal;
    logic start_ok;
    logic adv;
    logic issue;
    logic finish;

    assign legal    = (bus.kernel_dim != '0) && (bus.kernel_dim <= K_MAX);
    assign start_ok = (state == IDLE) && bus.start && legal;
    assign adv      = !out_valid_q || bus.out_ready;
    assign issue    = (state == FETCH) && adv;
    assign finish   = (state == DRAIN) && out_valid_q && bus.out_ready && out_last_q;

    window_addr_gen #(
        .IMAGE_WIDTH  (IMAGE_WIDTH),
        .IMAGE_HEIGHT (IMAGE_HEIGHT),
        .NUM_UNITS    (NUM_UNITS),
        .MAX_KERNEL   (MAX_KERNEL)
    ) u_addr_gen (
        .clk         (clk),
        .reset       (reset),
        .load        (start_ok),
        .kernel_dim  (bus.kernel_dim),
        .base_addr   (bus.base_addr),
        .enable      (state == FETCH),
        .stall       (!adv),
        .addr        (rd_addr),
        .pad         (rd_pad),
        .first_issue (first_issue),
        .last_issue  (last_issue)
    );

    // Non-blocking write against the registered read below gives
    // read-before-write on a same-cycle address collision.
    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            rd_first    <= 1'b0;
            rd_last     <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (legal) begin
                            state <= FETCH;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (issue && last_issue) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (finish) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // busy follows the FSM one cycle late on entry but drops together
            // with the done pulse on exit.
            busy_q <= (state != IDLE) && !finish;

            if (adv) begin
                rd_valid <= issue;
                rd_first <= issue && first_issue;
                rd_last  <= issue && last_issue;
                if (issue) begin
                    for (int u = 0; u < NUM_UNITS; u++) begin
                        rd_data[u] <= rd_pad[u] ? '0 : mem[rd_addr[u]];
                    end
                end

                out_valid_q <= rd_valid;
                out_first_q <= rd_first;
                out_last_q  <= rd_last;
                if (rd_valid) begin
                    out_q <= rd_data;
                end
            end
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_first = out_first_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_window_fetch_unit.sv
// tb/tb_window_fetch_unit.sv - self-checking bench for window_fetch_unit
module tb_window_fetch_unit;
    import window_fetch_pkg::*;

    localparam int DW = 16;
    localparam int IW = 8;
    localparam int IH = 8;
    localparam int NU = 2;
    localparam int MK = 4;

    typedef logic [33:0] beat_t;

    typedef struct {
        int k;
        int b0;
        int b1;
        bit toggle;
        bit exp_err;
        int exp_lat;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int checks     = 0;
    int errors     = 0;
    int cyc        = 0;
    int beats_seen = 0;
    bit ready_toggle = 1'b0;

    beat_t       sb[$];
    logic [15:0] mdl [64];
    vec_t        vecs [7];

    int c1_u0 [9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
    int c1_u1 [9] = '{9, 10, 11, 17, 18, 19, 25, 26, 27};
`ifdef WINDOW_ZERO_PAD_EN
    int w63 [4] = '{63, 0, 0, 0};
`else
    int w63 [4] = '{63, 0, 7, 8};
`endif
    int w00 [4] = '{0, 1, 8, 9};

    window_fetch_unit_if #(
        .DATA_WIDTH(DW), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .NUM_UNITS(NU), .MAX_KERNEL(MK)
    ) bus ();

    window_fetch_unit #(
        .DATA_WIDTH(DW), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .NUM_UNITS(NU), .MAX_KERNEL(MK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        bus.out_ready = ready_toggle ? (cyc % 3 == 0) : 1'b1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: one pop per handshake, plus a hold check on stalls.
    beat_t held;
    bit    stalled = 1'b0;
    always @(negedge clk) begin
        beat_t act;
        beat_t exp_b;
        act = {bus.out[0], bus.out[1], bus.out_first, bus.out_last};
        if (reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_hold", {bus.out_valid, act}, {1'b1, held});
            end
            if (bus.out_valid && bus.out_ready) begin
                beats_seen++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%h expected=none", act);
                end else begin
                    exp_b = sb.pop_front();
                    check("beat", act, exp_b);
                end
            end
            stalled = bus.out_valid && !bus.out_ready;
            held    = act;
        end
    end

    function automatic logic [15:0] model_elem(input int b, input int r, input int c);
`ifdef WINDOW_ZERO_PAD_EN
        int col;
        int row;
        col = (b % IW) + c;
        row = (b / IW) + r;
        if (col >= IW || row >= IH) return 16'h0;
        return mdl[row * IW + col];
`else
        return mdl[(b + r * IW + c) % (IW * IH)];
`endif
    endfunction

    task automatic push_model(input int k, input int b0, input int b1);
        for (int r = 0; r < k; r++) begin
            for (int c = 0; c < k; c++) begin
                sb.push_back({model_elem(b0, r, c), model_elem(b1, r, c),
                              1'(r == 0 && c == 0), 1'(r == k - 1 && c == k - 1)});
            end
        end
    endtask

    task automatic write_word(input int a, input int d);
        @(posedge clk); #1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 6'(a);
        bus.wr_data = 16'(d);
        @(posedge clk); #1;
        bus.wr_en   = 1'b0;
        mdl[a]      = 16'(d);
    endtask

    task automatic drive_start(input int k, input int b0, input int b1);
        @(posedge clk); #1;
        bus.start        = 1'b1;
        bus.kernel_dim   = 3'(k);
        bus.base_addr[0] = 6'(b0);
        bus.base_addr[1] = 6'(b1);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // n counts cycles after the edge that accepted start; values are sampled #1 after each edge.
    task automatic run_window(input int k, input int b0, input int b1, input bit toggle,
                              input bit exp_err, input int exp_lat,
                              input int wr_at, input int wr_a, input int wr_d);
        int n;
        int lat;
        int first_v;
        bit got_done;
        bit saw_err;
        ready_toggle = toggle;
        drive_start(k, b0, b1);
        if (exp_err) begin
            check("illegal_start_err_busy_valid", {bus.err, bus.busy, bus.out_valid}, 3'b100);
            @(posedge clk); #1;
            check("illegal_start_after", {bus.err, bus.busy, bus.out_valid}, 3'b000);
            ready_toggle = 1'b0;
            return;
        end
        check("busy_at_accept", bus.busy, 1'b0);
        n = 0; lat = -1; first_v = -1; got_done = 1'b0; saw_err = 1'b0;
        while (!got_done && n < 300) begin
            if (n == 1) begin
                check("busy_after_start", bus.busy, 1'b1);
                bus.start      = 1'b1;
                bus.kernel_dim = 3'd0;
            end
            if (n == 2) bus.start = 1'b0;
            if (wr_at > 0 && n == wr_at - 1) begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = 6'(wr_a);
                bus.wr_data = 16'(wr_d);
            end
            if (wr_at > 0 && n == wr_at) bus.wr_en = 1'b0;
            if (bus.out_valid && first_v < 0) first_v = n;
            if (bus.err) saw_err = 1'b1;
            if (bus.done) begin
                got_done = 1'b1;
                lat      = n;
                check("busy_low_at_done", bus.busy, 1'b0);
            end else begin
                @(posedge clk); #1;
                n++;
            end
        end
        if (!got_done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=none expected=done within 300 cycles");
        end
        if (exp_lat > 0) begin
            check("done_latency", 64'(lat), 64'(exp_lat));
            check("first_valid_latency", 64'(first_v), 64'd2);
        end
        check("no_err_outside_idle", saw_err, 1'b0);
        check("all_beats_delivered", 64'(sb.size()), 64'd0);
        ready_toggle = 1'b0;
    endtask

    initial begin
        int target;
        int guard;

        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.start      = 1'b0;
        bus.kernel_dim = '0;
        bus.base_addr  = '0;
        bus.out_ready  = 1'b1;

        vecs[0] = '{3, 0, 9, 1'b1, 1'b0, 0};
        vecs[1] = '{0, 0, 0, 1'b0, 1'b1, 0};
        vecs[2] = '{5, 0, 0, 1'b0, 1'b1, 0};
        vecs[3] = '{1, 5, 60, 1'b0, 1'b0, 3};
        vecs[4] = '{4, 20, 36, 1'b0, 1'b0, 18};
        vecs[5] = '{4, 60, 0, 1'b1, 1'b0, 0};
        vecs[6] = '{2, 62, 57, 1'b0, 1'b0, 6};

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {bus.out, bus.out_valid, bus.out_first, bus.out_last,
                              bus.busy, bus.done, bus.err}, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 64; i++) write_word(i, i);

        for (int i = 0; i < 9; i++) begin
            sb.push_back({16'(c1_u0[i]), 16'(c1_u1[i]), 1'(i == 0), 1'(i == 8)});
        end
        run_window(3, 0, 9, 1'b0, 1'b0, 11, 0, 0, 0);

        for (int i = 0; i < 4; i++) begin
            sb.push_back({16'(w63[i]), 16'(w00[i]), 1'(i == 0), 1'(i == 3)});
        end
        run_window(2, 63, 0, 1'b0, 1'b0, 6, 0, 0, 0);

        for (int i = 0; i < 7; i++) begin
            if (!vecs[i].exp_err) push_model(vecs[i].k, vecs[i].b0, vecs[i].b1);
            run_window(vecs[i].k, vecs[i].b0, vecs[i].b1, vecs[i].toggle,
                       vecs[i].exp_err, vecs[i].exp_lat, 0, 0, 0);
        end

        push_model(3, 0, 9);
        target = beats_seen + 4;
        drive_start(3, 0, 9);
        guard = 0;
        while (beats_seen < target && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("reset_wait_beats", 64'(beats_seen - target + 4), 64'd4);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_window_reset", {bus.out, bus.out_valid, bus.out_first, bus.out_last,
                                   bus.busy, bus.done, bus.err}, 64'd0);
        sb.delete();
        push_model(2, 0, 9);
        run_window(2, 0, 9, 1'b0, 1'b0, 6, 0, 0, 0);

        push_model(3, 0, 40);
        run_window(3, 0, 40, 1'b0, 1'b0, 11, 6, 10, 16'hABCD);
        mdl[10] = 16'hABCD;
        push_model(3, 0, 40);
        run_window(3, 0, 40, 1'b0, 1'b0, 11, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/window_fetch_unit.md
# window_fetch_unit

Parametrised convolution-window fetcher for the TTPU datapath. Holds the image in an internal writable memory and, per start command, streams a square kernel_dim × kernel_dim window in row-major order to NUM_UNITS parallel processing units, one element per unit per accepted beat. It generalises the fixed-step image reader with:
- an image load port;
- a runtime kernel size up to MAX_KERNEL;
- a valid/ready output handshake with back-pressure;
- explicit first/last/done framing;
- optional edge zero-padding.

## Interface
Parameters:
- DATA_WIDTH, 16, element width
- IMAGE_WIDTH, 8, image columns (power of two)
- IMAGE_HEIGHT, 8, image rows (power of two)
- NUM_UNITS, 2, parallel output channels
- MAX_KERNEL, 4, largest legal kernel_dim

Derived widths:
- AW = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT)
- KW = $clog2(MAX_KERNEL+1)

Ports:
- clk  in  1  clock; one clock domain; reset is synchronous and active-high
- reset  in  1  synchronous, active-high
- wr_en  in  1  image memory write strobe
- wr_addr  in  AW  write address (row*IMAGE_WIDTH+col)
- wr_data  in  DATA_WIDTH  write data
- start  in  1  window request, sampled only in IDLE
- kernel_dim  in  KW  window side, latched on start
- base_addr  in  [NUM_UNITS][AW]  window top-left address per unit, latched on start
- out  out  [NUM_UNITS][DATA_WIDTH]  window elements
- out_valid  out  1  out holds a valid beat
- out_ready  in  1  consumer accepts beat
- out_first  out  1  beat is element (0,0)
- out_last  out  1  beat is element (k-1,k-1)
- busy  out  1  window in progress
- done  out  1  one-cycle pulse after the last handshake
- err  out  1  one-cycle pulse on an illegal start

## Operation
- FSM states: IDLE, FETCH, DRAIN.
- IDLE, start=1, 1 ≤ kernel_dim ≤ MAX_KERNEL:
  - latch kernel_dim and base_addr;
  - clear row/col counters;
  - go to FETCH.
- IDLE, start=1, kernel_dim = 0 or > MAX_KERNEL: pulse err, remain in IDLE.
- start outside IDLE is ignored (no err).
- FETCH:
  - Issue reads for element (r,c) of every unit.
  - Advance c, then r, only when the output register is empty or being consumed (out_ready & out_valid).
  - After issuing (k-1,k-1), go to DRAIN.
- DRAIN: hold until the last beat is accepted, then pulse done and return to IDLE.
- Address per unit: base_addr + r*IMAGE_WIDTH + c, computed modulo IMAGE_WIDTH*IMAGE_HEIGHT (wrap-around).
- Element count per window: kernel_dim², counted in KW-wide r/c counters. Arithmetic is unsigned.
- Write port:
  - active in every state;
  - a same-cycle read of the written address returns the old data (read-before-write);
  - memory is not cleared by reset.
- out is stable while out_valid=1 and out_ready=0.
- out_valid never drops without a handshake.

## Timing
- Reset values: out=0, out_valid=0, out_first=0, out_last=0, busy=0, done=0, err=0, state=IDLE.
- Reset mid-window aborts immediately. No done pulse; memory is kept.
- Read latency is one cycle. For start accepted at edge T:
  - busy=1 from T+1;
  - first out_valid at T+2.
- With out_ready held high, one beat per cycle:
  - last beat at T+1+k²;
  - done=1 and busy=0 in the cycle after the last handshake.
- A new start is accepted in the cycle done is high at the earliest (FSM is already in IDLE).
- err pulses in the cycle after the illegal start.
- Back-pressure: a low out_ready stalls the counters with no beat lost or duplicated. Throughput is 1 beat/cycle.

## Configuration
- WINDOW_ZERO_PAD_EN defined:
  - base column = base_addr % IMAGE_WIDTH, base row = base_addr / IMAGE_WIDTH;
  - an element whose column ≥ IMAGE_WIDTH or row ≥ IMAGE_HEIGHT outputs 0 for that unit;
  - no wrap occurs; beat count and timing are unchanged.
- WINDOW_ZERO_PAD_EN undefined: linear modulo wrap as in Operation, with no pad logic.

## Structure
- Package window_fetch_pkg:
  - fsm_state_t enum (IDLE, FETCH, DRAIN);
  - AW/KW helper functions;
  - default parameter constants.
- Sub-module window_addr_gen:
  - r/c counters, per-unit address and pad flag generation;
  - stall input;
  - last-issue flag.
- The top holds the memory array, FSM, output register and handshake.

## Test plan
- Write image mem[i]=i (64 words). Start with k=3, base={0,9}, out_ready=1 → unit0 gets 0,1,2,8,9,10,16,17,18 and unit1 gets 9,10,11,17,18,19,25,26,27. out_first on beat 1, out_last on beat 9, done at T+11.
- Same window with out_ready toggling 1,0,0,1,… → identical sequence, each beat held stable while stalled, done only after the 9th handshake.
- Start with kernel_dim=0, then kernel_dim=5 → err pulse each time, busy stays 0, no out_valid.
- Start with k=2, base=63 → without the macro: 63,0,7,8 (linear wrap). With WINDOW_ZERO_PAD_EN: 63,0,0,0.
- Assert reset after the 4th beat of a k=3 window → all outputs 0 next cycle. A new k=2 start then streams correctly with unchanged memory.
- Write mem[10]=0xABCD in the same cycle as its read → the window shows the old value 10; a following window shows 0xABCD.
